// File: rtl/asp_irq_responder.sv
// Receives ASP IRQ lines, captures rising edges as sticky pending bits and emits one
// valid/ack interrupt message per edge. Optional message counter: ASP_IRQ_MSG_COUNT_EN.
module asp_irq_responder #(
    parameter int NUM_IRQ_LINES = 4,
    parameter int NUM_IRQ_USED  = 3
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_IRQ_LINES-1:0]         irq_in,
    output logic                             irq_msg_valid,
    output logic [$clog2(NUM_IRQ_LINES)-1:0] irq_msg_vector,
    input  logic                             irq_msg_ack,
    input  logic [1:0]                       avs_address,
    input  logic                             avs_read,
    input  logic                             avs_write,
    input  logic [63:0]                      avs_writedata,
    input  logic [7:0]                       avs_byteenable,
    output logic [63:0]                      avs_readdata,
    output logic                             avs_readdatavalid,
    output logic                             avs_waitrequest
);

    localparam int VEC_W = $clog2(NUM_IRQ_LINES);
    localparam logic [NUM_IRQ_LINES-1:0] LIVE_MASK =
        NUM_IRQ_LINES'((64'd1 << NUM_IRQ_USED) - 64'd1);

    localparam logic [1:0] ADDR_STATUS = 2'd0;
    localparam logic [1:0] ADDR_MASK   = 2'd1;
    localparam logic [1:0] ADDR_CLEAR  = 2'd2;
    localparam logic [1:0] ADDR_INFO   = 2'd3;

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    state_t                   state_q, state_d;
    logic [VEC_W-1:0]         vec_q, vec_d;
    logic [NUM_IRQ_LINES-1:0] irq_prev_q, irq_prev_d;
    logic [NUM_IRQ_LINES-1:0] pending_q, pending_d;
    logic [NUM_IRQ_LINES-1:0] sent_q, sent_d;
    logic [NUM_IRQ_LINES-1:0] mask_q, mask_d;
    logic [63:0]              rdata_q, rdata_d;
    logic                     rvalid_q, rvalid_d;

    logic [63:0]              be_mask;
    logic [63:0]              wdata_be;
    logic                     wr_mask, wr_clear, wr_info;
    logic [NUM_IRQ_LINES-1:0] clear_bits;
    logic [NUM_IRQ_LINES-1:0] rise;
    logic [NUM_IRQ_LINES-1:0] eligible;
    logic [NUM_IRQ_LINES-1:0] sent_set;
    logic [VEC_W-1:0]         pick_idx;
    logic                     ack_fire;
    logic [31:0]              msg_count;
    logic [63:0]              rd_mux;

    always_comb begin
        for (int b = 0; b < 8; b++) begin
            be_mask[b*8 +: 8] = {8{avs_byteenable[b]}};
        end
        wdata_be   = avs_writedata & be_mask;
        wr_mask    = avs_write && (avs_address == ADDR_MASK);
        wr_clear   = avs_write && (avs_address == ADDR_CLEAR);
        wr_info    = avs_write && (avs_address == ADDR_INFO);
        clear_bits = wr_clear ? (wdata_be[NUM_IRQ_LINES-1:0] & LIVE_MASK) : '0;
        rise       = irq_in & ~irq_prev_q & LIVE_MASK;
        eligible   = pending_q & ~sent_q & ~mask_q;
        ack_fire   = (state_q == REQ) && irq_msg_ack;
    end

    // Fixed priority: iterate downwards so the lowest eligible index wins.
    always_comb begin
        pick_idx = '0;
        for (int i = NUM_IRQ_LINES - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                pick_idx = VEC_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        case (state_q)
            IDLE: begin
                if (eligible != '0) begin
                    vec_d   = pick_idx;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (irq_msg_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A new edge always wins over CLEAR, and re-arms the line for a fresh message.
    // An ack only marks sent if the line is still pending after any clear.
    always_comb begin
        sent_set = '0;
        if (ack_fire) begin
            sent_set[vec_q] = 1'b1;
        end
        irq_prev_d = irq_in;
        pending_d  = (pending_q & ~clear_bits) | rise;
        sent_d     = ((sent_q & ~clear_bits) | (sent_set & pending_q & ~clear_bits)) & ~rise;
        mask_d     = mask_q;
        if (wr_mask) begin
            mask_d = (mask_q & ~be_mask[NUM_IRQ_LINES-1:0])
                   | (wdata_be[NUM_IRQ_LINES-1:0] & LIVE_MASK);
        end
    end

`ifdef ASP_IRQ_MSG_COUNT_EN
    logic [31:0] msg_count_q, msg_count_d;

    always_comb begin
        msg_count_d = msg_count_q;
        if (wr_info && (avs_byteenable[7:4] != 4'h0)) begin
            msg_count_d = '0;
        end else if (ack_fire && (msg_count_q != 32'hFFFF_FFFF)) begin
            msg_count_d = msg_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            msg_count_q <= '0;
        end else begin
            msg_count_q <= msg_count_d;
        end
    end

    assign msg_count = msg_count_q;
`else
    assign msg_count = '0;
`endif

    // Reads sample registered state, so a same-cycle write is not yet visible.
    always_comb begin
        rd_mux = '0;
        case (avs_address)
            ADDR_STATUS: rd_mux = 64'(pending_q);
            ADDR_MASK:   rd_mux = 64'(mask_q);
            ADDR_CLEAR:  rd_mux = '0;
            ADDR_INFO:   rd_mux = {msg_count, 16'h0000, 8'(NUM_IRQ_USED), 8'(NUM_IRQ_LINES)};
            default:     rd_mux = '0;
        endcase
        rdata_d  = avs_read ? rd_mux : '0;
        rvalid_d = avs_read;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            vec_q      <= '0;
            irq_prev_q <= '0;
            pending_q  <= '0;
            sent_q     <= '0;
            mask_q     <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            irq_prev_q <= irq_prev_d;
            pending_q  <= pending_d;
            sent_q     <= sent_d;
            mask_q     <= mask_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{wdata_be[63:NUM_IRQ_LINES], wr_info};

    assign irq_msg_valid     = (state_q == REQ);
    assign irq_msg_vector    = vec_q;
    assign avs_readdata      = rdata_q;
    assign avs_readdatavalid = rvalid_q;
    assign avs_waitrequest   = ~reset_n;

endmodule
